// File: rtl/instruction_fetch.sv
// ============================================================================
//  instruction_fetch
//  Variable-length (one or two word) instruction fetch with memory handshake,
//  redirect, decode hand-off and halt.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [2:0]  OPC_I_TYPE = 3'b001,
   parameter logic [2:0]  OPC_M_TYPE = 3'b100
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [15:0] instruction,
   output logic [15:0] imm_word,
   output logic [15:0] inst_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      FETCH1 = 2'd0,
      FETCH2 = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic        xfer;
   logic        is_double;

   assign xfer      = mem_req & mem_ready;
   assign is_double = (mem_rdata[2:0] == OPC_I_TYPE) || (mem_rdata[2:0] == OPC_M_TYPE);
   assign mem_addr  = pc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FETCH1;
         pc          <= RESET_PC;
         instruction <= 16'h0000;
         imm_word    <= 16'h0000;
         inst_pc     <= 16'h0000;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         mem_req     <= 1'b0;
      end else begin
         case (state)
            FETCH1: begin
               if (redirect) begin
                  pc      <= redirect_pc;
                  mem_req <= 1'b1;
               end else if (xfer) begin
                  instruction <= mem_rdata;
                  inst_pc     <= pc;
                  pc          <= pc + 16'd1;
                  if (is_double) begin
                     state <= FETCH2;
                  end else begin
                     imm_word   <= 16'h0000;
                     state      <= HOLD;
                     mem_req    <= 1'b0;
                     inst_valid <= 1'b1;
                  end
               end else begin
                  // first cycle out of reset lands here with mem_req still low
                  mem_req <= 1'b1;
               end
            end
            FETCH2: begin
               if (redirect) begin
                  pc      <= redirect_pc;
                  state   <= FETCH1;
                  mem_req <= 1'b1;
               end else if (xfer) begin
                  imm_word   <= mem_rdata;
                  pc         <= pc + 16'd1;
                  state      <= HOLD;
                  mem_req    <= 1'b0;
                  inst_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc         <= redirect_pc;
                  state      <= FETCH1;
                  mem_req    <= 1'b1;
                  inst_valid <= 1'b0;
               end else if (inst_ready) begin
                  inst_valid <= 1'b0;
                  if (halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     state   <= FETCH1;
                     mem_req <= 1'b1;
                  end
               end
            end
            HALTED: begin
               mem_req    <= 1'b0;
               inst_valid <= 1'b0;
               halted     <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: word address of the first fetch after reset.
REQ-002 Parameter OPC_I_TYPE, default 3'b001: instruction[2:0] encoding of I-type (double-word).
REQ-003 Parameter OPC_M_TYPE, default 3'b100: instruction[2:0] encoding of M-type (double-word).
REQ-004 Port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: mem_req  out  1  read request to instruction memory.
REQ-007 Port: mem_addr  out  16  word address of the requested read.
REQ-008 Port: mem_ready  in  1  memory has mem_rdata valid this cycle.
REQ-009 Port: mem_rdata  in  16  read data.
REQ-010 Port: redirect  in  1  taken branch/jump from execute.
REQ-011 Port: redirect_pc  in  16  target word address, valid with redirect.
REQ-012 Port: halt  in  1  decode reports SYS_END for the presented instruction.
REQ-013 Port: inst_valid  out  1  instruction, imm_word and inst_pc are valid.
REQ-014 Port: inst_ready  in  1  decode accepts the presented instruction.
REQ-015 Port: instruction  out  16  first instruction word.
REQ-016 Port: imm_word  out  16  second word for double-word instructions, else 16'h0000.
REQ-017 Port: inst_pc  out  16  word address of the first instruction word.
REQ-018 Port: halted  out  1  fetch is stopped.

Function
REQ-019 FSM states SHALL be FETCH1, FETCH2, HOLD and HALTED.
REQ-020 Memory handshake: a word transfers on a cycle with mem_req=1 and mem_ready=1; mem_req and mem_addr are held stable until then.
REQ-021 FETCH1: mem_req=1, mem_addr=pc; on transfer, latch instruction=mem_rdata, inst_pc=pc, pc=pc+1.
REQ-022 On the FETCH1 transfer, if mem_rdata[2:0] is OPC_I_TYPE or OPC_M_TYPE, go to FETCH2; otherwise set imm_word=0 and go to HOLD.
REQ-023 FETCH2: mem_req=1, mem_addr=pc; on transfer, latch imm_word=mem_rdata, set pc=pc+1 and go to HOLD.
REQ-024 HOLD: inst_valid=1 and mem_req=0; outputs stay constant until inst_ready=1.
REQ-025 HOLD with inst_ready=1 and halt=0 goes to FETCH1; with inst_ready=1 and halt=1 it goes to HALTED.
REQ-026 HALTED: mem_req=0, inst_valid=0 and halted=1; only reset leaves HALTED.
REQ-027 In HALTED, redirect and halt are ignored.
REQ-028 In any other state, redirect=1 takes priority over all other events and sets pc=redirect_pc.
REQ-029 On redirect, the next state is FETCH1 and inst_valid=0 from the next cycle.
REQ-030 On redirect, data transferring in the same cycle is discarded, and any held or partial instruction is dropped.
REQ-031 pc arithmetic SHALL be modulo 2^16; 16'hFFFF+1 wraps to 16'h0000, including between the two words of a double-word instruction.
REQ-032 Minimum latency with mem_ready=1 continuously: single-word instruction, FETCH1 request to inst_valid = 1 cycle; double-word = 2 cycles.
REQ-033 Throughput: with inst_ready=1, a new single-word instruction is presented every 2 cycles.
REQ-034 inst_valid SHALL be a registered output, never combinational from inputs.

Reset
REQ-035 While reset_n=0, regardless of clock: state=FETCH1, pc=RESET_PC, and instruction, imm_word and inst_pc are 16'h0000.
REQ-036 While reset_n=0, inst_valid=0, halted=0 and mem_req=0.
REQ-037 mem_req asserts on the first rising clock edge after reset_n rises.
REQ-038 Reset asserted mid-transfer or in HALTED aborts immediately; memory data presented during reset is ignored.

Verification
REQ-039 Reset, mem_ready=1, memory[0]=16'h1230 (single-word) -> mem_addr=0, then inst_valid=1, instruction=16'h1230, imm_word=0, inst_pc=0; the next fetch is at address 1.
REQ-040 memory[4]=16'h2201 (I-type), memory[5]=16'hBEEF, pc=4 -> two transfers, then instruction=16'h2201, imm_word=16'hBEEF, inst_pc=4; the next pc is 6.
REQ-041 mem_ready held 0 for 3 cycles in FETCH1 -> mem_req and mem_addr stable throughout; capture occurs only on the mem_ready=1 cycle.
REQ-042 redirect=1, redirect_pc=16'h0040 in FETCH2 while mem_ready=1 -> imm_word is not updated and no inst_valid is produced; the next cycle mem_addr=16'h0040.
REQ-043 HOLD with inst_ready=0 for 5 cycles -> outputs stable; then inst_ready=1 with halt=1 -> HALTED, halted=1, mem_req=0; a later redirect is ignored.
REQ-044 pc=16'hFFFF holding an M-type instruction -> second word fetched at 16'h0000, inst_pc=16'hFFFF; the next fetch is at 16'h0001.
